serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
// - Multicycle signed subtractor: computes data_operandA - data_operandB, DIGIT_W bits per cycle, LSB digit first.
// - Producer end of the compare path: drives sub_result and sub_overflow to the branch-condition logic.
// - Also drives the derived flags is_not_equal and is_less_than.
// - Serves the multicycle/low-area execute-stage variant, in place of a single-cycle 32-bit subtractor.
// PARAMETERS
// - WIDTH    32  operand/result width in bits.
// - DIGIT_W  4   bits processed per cycle. Must divide WIDTH. N = WIDTH/DIGIT_W cycles per operation.
// PORTS
// - clock          in   1      single clock, rising edge
// - reset          in   1      synchronous, active-high
// - ctrl_sub       in   1      start request, sampled on rising edge
// - data_operandA  in   WIDTH  minuend, latched on accepted start
// - data_operandB  in   WIDTH  subtrahend, latched on accepted start
// - busy           out  1      high while an operation is in progress (RUN)
// - result_ready   out  1      one-cycle pulse: outputs below are valid and final
// - sub_result     out  WIDTH  A-B, two's complement, truncated to WIDTH
// - sub_overflow   out  1      signed overflow of A-B
// - is_not_equal   out  1      |sub_result | sub_overflow
// - is_less_than   out  1      sub_result[WIDTH-1] ^ sub_overflow (signed A<B)
// BEHAVIOUR
// - Reset: state=IDLE. busy, result_ready, sub_result, sub_overflow, is_not_equal and is_less_than are all 0.
// - Reset wins over every other input in the same cycle.
// - Reset mid-operation aborts the operation. No result_ready is produced for it.
// - States: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE, ctrl_sub=1 at edge 0: latch A and B, digit count=0, carry=1, go to RUN. busy=1 from edge 0.
//   - RUN: on each edge, compute {c,d} = A_dig + ~B_dig + carry. Shift d into the result register at the MSB end.
//   - RUN: after the Nth digit (edge N), go to DONE and set busy=0.
//   - DONE: result_ready=1 for exactly one cycle (the cycle after edge N). On edge N+1 go to IDLE.
// - Latency: start at edge 0 -> result_ready high in cycle N+1 (N=8 at defaults). Throughput is 1 operation per N+2 cycles.
// - ctrl_sub is ignored in RUN and DONE. It is never queued. Operands are not re-sampled during an operation.
// - Output hold: sub_result and all flags update only on entry to DONE.
//   - They hold their value until the next entry to DONE or until reset.
//   - They never expose partial digits.
// - Overflow: sub_overflow = (A[MSB] != B[MSB]) && (sub_result[MSB] != A[MSB]). Final carry-out is discarded.
// - Wrap-around: the result is modulo 2^WIDTH, e.g. 0 - 1 = all ones with overflow 0.
// STRUCTURE
// - Shared include (cpu_defs.vh): WIDTH default and the state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
// - Sub-module sub_digit_slice: combinational DIGIT_W-bit A + ~B + cin -> {cout, diff}. Instantiated once, reused every cycle.
// - Top level holds the FSM, digit counter, operand shift registers, carry flop and result/flag registers.
// TESTING
// - 5 - 3 (DIGIT_W=4):
//   - busy=1 for cycles 1..8; result_ready pulses once in cycle 9.
//   - sub_result=2, sub_overflow=0, is_not_equal=1, is_less_than=0.
// - 7 - 7: sub_result=0, sub_overflow=0, is_not_equal=0, is_less_than=0.
// - 0x80000000 - 1: sub_result=0x7FFFFFFF, sub_overflow=1, is_not_equal=1, is_less_than=1.
// - 0x7FFFFFFF - 0xFFFFFFFF: sub_result=0x80000000, sub_overflow=1, is_less_than=0.
// - Start 5-3, pulse ctrl_sub again at cycle 3 with 9-1:
//   - The second request is ignored; sub_result=2.
//   - A new start in IDLE after DONE gives 9-1=8.
// - Start 5-3, assert reset at cycle 4:
//   - Next cycle: busy=0 and all outputs 0.
//   - No result_ready for 20 cycles.
//   - A following start 4-6 gives 0xFFFFFFFE, is_less_than=1.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: default sizing and FSM encoding.
package serial_subtractor_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int DIGIT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_digit_slice.sv
// One DIGIT_W-bit slice of A + ~B + cin; reused every cycle by the serial subtractor.
module serial_subtractor_digit_slice #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_diff,
  output logic               o_cout
);

  logic [DIGIT_W:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, ~i_b} + {{DIGIT_W{1'b0}}, i_cin};
  assign o_diff = w_sum[DIGIT_W-1:0];
  assign o_cout = w_sum[DIGIT_W];

endmodule

// File: rtl/serial_subtractor.sv
// Multicycle signed subtractor: A-B computed DIGIT_W bits per cycle, LSB digit first.
// state | meaning
// IDLE  | waiting for ctrl_sub; operands latched on accept
// RUN   | one digit per edge, N edges total
// DONE  | result_ready pulse; outputs already final
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_sub,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] sub_result,
  output logic             sub_overflow,
  output logic             is_not_equal,
  output logic             is_less_than
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [DIGIT_W-1:0] w_diff;
  logic               w_cout;
  logic               w_start;
  logic               w_last;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_acc_nxt;

  serial_subtractor_digit_slice #(.DIGIT_W(DIGIT_W)) u_slice (
    .i_a    (r_opa[DIGIT_W-1:0]),
    .i_b    (r_opb[DIGIT_W-1:0]),
    .i_cin  (r_carry),
    .o_diff (w_diff),
    .o_cout (w_cout)
  );

  assign w_start   = (r_state == IDLE) && ctrl_sub;
  assign w_last    = (r_state == RUN) && (r_cnt == '0);
  assign w_acc_nxt = (r_acc >> DIGIT_W) | (WIDTH'(w_diff) << (WIDTH - DIGIT_W));
  // On the last digit the low digit of each operand register holds the operand MSBs.
  assign w_ovf     = (r_opa[DIGIT_W-1] != r_opb[DIGIT_W-1]) &&
                     (w_diff[DIGIT_W-1] != r_opa[DIGIT_W-1]);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ctrl_sub) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:                  w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state == RUN);
    result_ready = (r_state == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa        <= '0;
      r_opb        <= '0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      r_cnt        <= '0;
      sub_result   <= '0;
      sub_overflow <= 1'b0;
      is_not_equal <= 1'b0;
      is_less_than <= 1'b0;
    end else if (w_start) begin
      r_opa   <= data_operandA;
      r_opb   <= data_operandB;
      r_acc   <= '0;
      r_carry <= 1'b1;
      r_cnt   <= CNT_W'(N - 1);
    end else if (r_state == RUN) begin
      r_opa   <= r_opa >> DIGIT_W;
      r_opb   <= r_opb >> DIGIT_W;
      r_acc   <= w_acc_nxt;
      r_carry <= w_cout;
      r_cnt   <= r_cnt - 1'b1;
      if (w_last) begin
        sub_result   <= w_acc_nxt;
        sub_overflow <= w_ovf;
        is_not_equal <= (|w_acc_nxt) | w_ovf;
        is_less_than <= w_acc_nxt[WIDTH-1] ^ w_ovf;
      end
    end
  end

endmodule
